tiny45_alu_seq: RTL
===================

Name: tiny45_alu_seq

Overview:
Sequencer that runs one 32-bit RISC-V ALU operation through the team's 4-bit nibble-serial ALU (tiny45_alu) over 8 consecutive cycles, least-significant nibble first.
- Latches operands and op, drives the ALU nibble ports, chains carry and compare between nibbles, and assembles the result.
- Sits between instruction decode and writeback.
- Uses a valid/ready handshake on both sides.

Parameters:
WIDTH, 32, operand/result width; must be a multiple of 4.
NIB, WIDTH/4, nibble cycles per operation (localparam, not overridable).

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
in_valid  in  1  request valid
in_ready  out  1  sequencer idle, request accepted when in_valid & in_ready
in_op  in  4  ALU op code: ADD 0000, SUB 1000, SLT 0010, SLTU 0011, AND 0111, OR 0110, XOR/EQ 0100
in_a  in  WIDTH  operand A
in_b  in  WIDTH  operand B
out_valid  out  1  result available
out_ready  in  1  consumer accepts result
out_d  out  WIDTH  result
out_cmp  out  1  final-nibble compare result (SLT/SLTU: A<B; XOR/EQ: A==B)
alu_op  out  4  to ALU op
alu_a  out  4  to ALU a (current nibble of A)
alu_b  out  4  to ALU b (current nibble of B)
alu_cy_in  out  1  to ALU cy_in
alu_cmp_in  out  1  to ALU cmp_in
alu_d  in  4  from ALU d
alu_cy_out  in  1  from ALU cy_out
alu_cmp_res  in  1  from ALU cmp_res

Behaviour:
- Reset (rstn low, async): state IDLE, nibble counter 0, all internal registers 0. Outputs: in_ready=1, out_valid=0, out_d=0, out_cmp=0, alu_* outputs 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On accept, latch in_op, in_a, in_b into shift registers.
  - Carry register = op[1] | op[3] (1 for SUB/SLT/SLTU). Compare register = 1. Counter = 0.
  - Go to RUN.
- RUN (exactly NIB cycles; in_ready=0):
  - alu_op = latched op; alu_a/alu_b = low nibble of shift registers; alu_cy_in = carry register; alu_cmp_in = compare register.
  - Each edge: carry register <= alu_cy_out; compare register <= alu_cmp_res; A and B shift right 4; alu_d shifts into the top nibble of the result register.
  - When counter == NIB-1, capture out_cmp = alu_cmp_res and go to DONE. Otherwise counter++.
- alu_* outputs are driven only in RUN; they are 0 in IDLE and DONE.
- DONE:
  - out_valid=1.
  - out_d = {WIDTH-1 zeros, out_cmp} when op[2:1]==01 (SLT/SLTU); otherwise the assembled result.
  - Hold out_d and out_cmp stable until out_valid & out_ready, then go to IDLE. out_valid drops the next cycle.
- Latency: accept at edge 0; nibbles presented during cycles 1..NIB; out_valid high from cycle NIB+1.
- No overlap: a new request cannot be accepted in the same cycle a result is consumed. Throughput is one op per NIB+2 cycles minimum.
- Shift op codes (0001, 0101, 1101) are accepted without error. They complete normally with out_d=0 and out_cmp=0.
- out_cmp for ADD/SUB/AND/OR is the raw final alu_cmp_res. It is defined but not meaningful to consumers.
- in_valid is ignored outside IDLE. in_* values are sampled only at accept.
- Reset asserted in any state returns to IDLE immediately. The in-flight op is discarded and no out_valid is produced.

Optional Feature:
TINY45_ALU_SEQ_ABORT_EN
- Defined: adds input port abort (1 bit). If abort=1 at an edge in RUN or DONE, go to IDLE. The result register and out_cmp clear to 0, and out_valid is never asserted for that op. In IDLE, abort is ignored. If abort and in_valid arrive in the same IDLE cycle, the request is accepted normally.
- Not defined: no abort port; behaviour as above.

Test Plan:
- ADD: a=0x0000FFFF, b=0x00000001 -> out_d=0x00010000. out_valid rises exactly 9 cycles after accept. alu_cy_in sequence 0,1,1,1,1,0,0,0.
- SUB: a=5, b=7 -> out_d=0xFFFFFFFE. alu_cy_in=1 on the first nibble.
- Compare, a=0xFFFFFFFF, b=0x00000001: SLT -> out_d=1, out_cmp=1. SLTU -> out_d=0, out_cmp=0.
- EQ: XOR with a=b=0x12345678 -> out_d=0, out_cmp=1. With a=0x12345679, b=0x12345678 -> out_d=1, out_cmp=0.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> out_d and out_cmp stable, in_ready=0, a concurrent in_valid is not accepted. Raise out_ready -> IDLE the next cycle.
- Reset mid-op: assert rstn=0 during nibble 3 of an ADD -> all outputs 0 asynchronously. After release, in_ready=1 and no out_valid. With TINY45_ALU_SEQ_ABORT_EN, the same check uses abort=1 instead of reset.

Source files
------------

// File: rtl/tiny45_alu_seq.sv
// ---------------------------------------------------------------------------
// tiny45_alu_seq
//
// Runs one WIDTH-bit RISC-V ALU operation through the external 4-bit
// nibble-serial ALU (tiny45_alu), one nibble per cycle, least-significant
// nibble first. Carry and compare are chained between nibbles through local
// registers, and the ALU result nibbles are assembled into out_d.
//
// Handshake (both sides): a transfer happens on a rising clk edge where
// valid and ready are both 1. in_ready is 1 only in IDLE. out_valid is 1
// only in DONE, and out_d/out_cmp hold steady until the result is consumed.
// Once a transfer is offered, the offering side keeps valid high and its
// data steady until the transfer happens.
//
// Optional feature macro: TINY45_ALU_SEQ_ABORT_EN adds an 'abort' input.
// When abort is 1 at an edge in RUN or DONE, the current op is dropped.
//
// Ports:
//   clk, rstn              clock, asynchronous active-low reset
//   in_valid/in_ready      request handshake
//   in_op, in_a, in_b      op code and operands, sampled on accept
//   out_valid/out_ready    result handshake
//   out_d, out_cmp         result and final-nibble compare flag
//   alu_op/a/b/cy_in/cmp_in   to the nibble ALU (driven only in RUN)
//   alu_d/cy_out/cmp_res      from the nibble ALU
//   abort                  (only with TINY45_ALU_SEQ_ABORT_EN) drop op
//   dbg_state              current FSM state (0 IDLE, 1 RUN, 2 DONE)
// ---------------------------------------------------------------------------
module tiny45_alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rstn,
`ifdef TINY45_ALU_SEQ_ABORT_EN
    input  logic             abort,
`endif
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_d,
    output logic             out_cmp,
    output logic [3:0]       alu_op,
    output logic [3:0]       alu_a,
    output logic [3:0]       alu_b,
    output logic             alu_cy_in,
    output logic             alu_cmp_in,
    input  logic [3:0]       alu_d,
    input  logic             alu_cy_out,
    input  logic             alu_cmp_res,
    output logic [1:0]       dbg_state
);

    localparam int NIB = WIDTH / 4;
    localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             cy_q, cy_d;
    logic             cmp_q, cmp_d;
    logic             ocmp_q, ocmp_d;
    logic             abort_hit;

    logic is_run, is_done, is_shift, is_cmp;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            cy_q    <= 1'b0;
            cmp_q   <= 1'b0;
            ocmp_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            cy_q    <= cy_d;
            cmp_q   <= cmp_d;
            ocmp_q  <= ocmp_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        res_d     = res_q;
        cy_d      = cy_q;
        cmp_d     = cmp_q;
        ocmp_d    = ocmp_q;
        abort_hit = 1'b0;
`ifdef TINY45_ALU_SEQ_ABORT_EN
        abort_hit = abort;
`endif
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    op_d    = in_op;
                    a_d     = in_a;
                    b_d     = in_b;
                    // SUB/SLT/SLTU compute A + ~B + 1, so the chain starts at 1.
                    cy_d    = in_op[1] | in_op[3];
                    cmp_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                cy_d  = alu_cy_out;
                cmp_d = alu_cmp_res;
                a_d   = a_q >> 4;
                b_d   = b_q >> 4;
                // Nibbles enter at the top; after NIB shifts nibble 0 sits at the bottom.
                res_d = {alu_d, res_q[WIDTH-1:4]};
                if (cnt_q == CW'(NIB - 1)) begin
                    ocmp_d  = alu_cmp_res;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (abort_hit && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            res_d   = '0;
            ocmp_d  = 1'b0;
            cnt_d   = '0;
        end
    end

    assign is_run   = (state_q == S_RUN);
    assign is_done  = (state_q == S_DONE);
    // Shift codes (0001, 0101, 1101) are the only ones with op[1:0] == 01.
    assign is_shift = (op_q[1:0] == 2'b01);
    assign is_cmp   = (op_q[2:1] == 2'b01);

    assign in_ready   = (state_q == S_IDLE);
    assign out_valid  = is_done;
    assign out_cmp    = is_done & ~is_shift & ocmp_q;
    assign out_d      = (!is_done || is_shift) ? '0 :
                        is_cmp ? {{(WIDTH-1){1'b0}}, ocmp_q} : res_q;

    assign alu_op     = is_run ? op_q     : 4'd0;
    assign alu_a      = is_run ? a_q[3:0] : 4'd0;
    assign alu_b      = is_run ? b_q[3:0] : 4'd0;
    assign alu_cy_in  = is_run & cy_q;
    assign alu_cmp_in = is_run & cmp_q;
    assign dbg_state  = state_q;

endmodule
